// File: rtl/pid_steering_controller.sv
// pid_steering_controller
// Per-frame fixed-point PID steering controller. Each accepted line-error frame
// runs a five-state pipeline (IDLE/LOAD/MUL/SUM/OUT) and publishes a new signed
// steer value plus differential wheel speeds with a one-cycle cmd_valid pulse.
// Consecutive empty frames (end_of_line rises) eventually declare the path lost,
// stop both wheels and clear the controller history.
module pid_steering_controller #(
  parameter int KP          = 64,
  parameter int KI          = 2,
  parameter int KD          = 32,
  parameter int SHIFT       = 8,
  parameter int ERR_CLAMP   = 511,
  parameter int I_LIMIT     = 4096,
  parameter int BASE_SPEED  = 160,
  parameter int OUT_MAX     = 255,
  parameter int LOST_FRAMES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [31:0] error,
  input  logic               error_ready,
  input  logic               end_of_line,
  output logic signed [15:0] steer,
  output logic [7:0]         left_speed,
  output logic [7:0]         right_speed,
  output logic               cmd_valid,
  output logic               lost_line
);

  localparam logic signed [31:0] KP_S     = 32'(KP);
  localparam logic signed [31:0] KI_S     = 32'(KI);
  localparam logic signed [31:0] KD_S     = 32'(KD);
  localparam logic signed [31:0] ERR_HI   = 32'(ERR_CLAMP);
  localparam logic signed [31:0] ERR_LO   = 32'(-ERR_CLAMP);
  localparam logic signed [31:0] INT_HI   = 32'(I_LIMIT);
  localparam logic signed [31:0] INT_LO   = 32'(-I_LIMIT);
  localparam logic signed [31:0] OUT_HI   = 32'(OUT_MAX);
  localparam logic signed [31:0] OUT_LO   = 32'(-OUT_MAX);
  localparam logic signed [31:0] BASE_S   = 32'(BASE_SPEED);
  localparam logic [7:0]         LOST_C   = 8'(LOST_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MUL,
    S_SUM,
    S_OUT
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // edge detection
  logic r_er_prev;
  logic r_eol_prev;
  logic w_er_rise;
  logic w_eol_rise;

  // datapath
  logic signed [31:0] r_e;
  logic signed [31:0] r_e_prev;
  logic signed [31:0] r_d;
  logic signed [31:0] r_integ;
  logic signed [31:0] r_pp;
  logic signed [31:0] r_pi;
  logic signed [31:0] r_pd;
  logic signed [15:0] r_u;
  logic signed [31:0] w_u_ext;
  logic [7:0]         r_lost_cnt;

  // outputs
  logic signed [15:0] r_steer;
  logic [7:0]         r_left;
  logic [7:0]         r_right;
  logic               r_cmd_valid;
  logic               r_lost_line;

  // Generic signed saturation to [lo, hi].
  function automatic logic signed [31:0] sat32(input logic signed [31:0] v,
                                               input logic signed [31:0] lo,
                                               input logic signed [31:0] hi);
    if (v < lo) begin
      return lo;
    end else if (v > hi) begin
      return hi;
    end else begin
      return v;
    end
  endfunction

  // Steer clamp to +/-OUT_MAX, narrowed to the 16-bit steer width.
  function automatic logic signed [15:0] clamp_steer(input logic signed [31:0] v);
    logic signed [31:0] t;
    t = sat32(v, OUT_LO, OUT_HI);
    return t[15:0];
  endfunction

  // Wheel speed clamp to 0..OUT_MAX, narrowed to 8 bits.
  function automatic logic [7:0] clamp_speed(input logic signed [31:0] v);
    logic signed [31:0] t;
    t = sat32(v, 32'sd0, OUT_HI);
    return t[7:0];
  endfunction

  assign w_er_rise  = error_ready & ~r_er_prev;
  assign w_eol_rise = end_of_line & ~r_eol_prev;
  assign w_u_ext    = 32'(r_u);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: an empty frame has priority and never starts a computation.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (!w_eol_rise && w_er_rise) begin
          w_state_next = S_LOAD;
        end
      end
      S_LOAD:  w_state_next = S_MUL;
      S_MUL:   w_state_next = S_SUM;
      S_SUM:   w_state_next = S_OUT;
      S_OUT:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Edge-detect history, PID datapath, lost-path tracking and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_er_prev   <= 1'b0;
      r_eol_prev  <= 1'b0;
      r_e         <= '0;
      r_e_prev    <= '0;
      r_d         <= '0;
      r_integ     <= '0;
      r_pp        <= '0;
      r_pi        <= '0;
      r_pd        <= '0;
      r_u         <= '0;
      r_lost_cnt  <= '0;
      r_steer     <= '0;
      r_left      <= '0;
      r_right     <= '0;
      r_cmd_valid <= 1'b0;
      r_lost_line <= 1'b0;
    end else begin
      r_er_prev   <= error_ready;
      r_eol_prev  <= end_of_line;
      r_cmd_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_eol_rise) begin
            if (r_lost_cnt < LOST_C) begin
              r_lost_cnt <= r_lost_cnt + 8'd1;
              if (r_lost_cnt == LOST_C - 8'd1) begin
                // Path declared lost: stop, forget history, announce once.
                r_lost_line <= 1'b1;
                r_steer     <= '0;
                r_left      <= '0;
                r_right     <= '0;
                r_integ     <= '0;
                r_e_prev    <= '0;
                r_cmd_valid <= 1'b1;
              end
            end
          end else if (w_er_rise) begin
            r_e <= sat32(error, ERR_LO, ERR_HI);
          end
        end
        S_LOAD: begin
          r_integ  <= sat32(r_integ + r_e, INT_LO, INT_HI);
          r_d      <= r_e - r_e_prev;
          r_e_prev <= r_e;
        end
        S_MUL: begin
          r_pp <= KP_S * r_e;
          r_pi <= KI_S * r_integ;
          r_pd <= KD_S * r_d;
        end
        S_SUM: begin
          r_u <= clamp_steer((r_pp + r_pi + r_pd) >>> SHIFT);
        end
        S_OUT: begin
          r_steer     <= r_u;
          r_left      <= clamp_speed(BASE_S - w_u_ext);
          r_right     <= clamp_speed(BASE_S + w_u_ext);
          r_cmd_valid <= 1'b1;
          r_lost_cnt  <= '0;
          r_lost_line <= 1'b0;
        end
        default: begin
          r_lost_cnt <= r_lost_cnt;
        end
      endcase
    end
  end

  assign steer       = r_steer;
  assign left_speed  = r_left;
  assign right_speed = r_right;
  assign cmd_valid   = r_cmd_valid;
  assign lost_line   = r_lost_line;

endmodule
